// File: rtl/led_pattern_gen_if.sv
// Pattern-select inputs and LED/heartbeat outputs of led_pattern_gen.
interface led_pattern_gen_if #(
    parameter int unsigned N_LEDS = 5
);
    logic [1:0]        MODE;
    logic              PAUSE;
    logic [N_LEDS-1:0] LED;
    logic              TICK;

    // Board-level driver of mode/pause, observer of the LEDs
    modport master (
        output MODE,
        output PAUSE,
        input  LED,
        input  TICK
    );

    // Pattern generator side
    modport slave (
        input  MODE,
        input  PAUSE,
        output LED,
        output TICK
    );
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled step tick drives one of four pattern
// engines (binary count, bounce scan, PWM breathe, blink) onto N_LEDS outputs.
module led_pattern_gen #(
    parameter int unsigned N_LEDS     = 5,
    parameter int unsigned PRESCALE_W = 20,
    parameter int unsigned PWM_W      = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    led_pattern_gen_if.slave  bus
);

    localparam int unsigned POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

    localparam logic [1:0] MODE_COUNT   = 2'd0;
    localparam logic [1:0] MODE_SCAN    = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;
    localparam logic [1:0] MODE_BLINK   = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [POS_W-1:0]      POS_ONE   = POS_W'(1);
    localparam logic [POS_W-1:0]      POS_LAST  = POS_W'(N_LEDS - 1);
    localparam logic [N_LEDS-1:0]     LED_ONE   = N_LEDS'(1);
    localparam logic [PWM_W-1:0]      LVL_ONE   = PWM_W'(1);
    localparam logic [PRESCALE_W-1:0] PRESC_ONE = PRESCALE_W'(1);

    // Prescaler and tick
    logic [PRESCALE_W-1:0] r_presc;
    logic                  r_tick;
    logic                  w_tick_int;

    // Mode tracking
    logic [1:0]            r_mode_q;
    logic                  w_mode_chg;

    // Pattern state
    logic [N_LEDS-1:0]     r_step;
    logic [POS_W-1:0]      r_pos;
    logic                  r_dir;
    logic [PWM_W-1:0]      r_level;
    logic                  r_blink;
    logic [PWM_W-1:0]      r_pwm_cnt;

    // Next pattern state on a tick
    logic [N_LEDS-1:0]     w_step_nxt;
    logic [POS_W-1:0]      w_pos_nxt;
    logic                  w_dir_nxt;
    logic [PWM_W-1:0]      w_level_nxt;
    logic                  w_blink_nxt;

    // LED drive
    logic [N_LEDS-1:0]     r_led;
    logic [N_LEDS-1:0]     w_led_nxt;

    assign w_tick_int = (r_presc == '1) && !bus.PAUSE;
    assign w_mode_chg = (bus.MODE != r_mode_q);

    assign bus.LED  = r_led;
    assign bus.TICK = r_tick;

    // Prescaler counts while running; TICK is the registered terminal count
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            if (!bus.PAUSE) begin
                r_presc <= r_presc + PRESC_ONE;
            end
            r_tick <= w_tick_int;
        end
    end

    // Advance only the engine that is currently selected
    always_comb begin
        w_step_nxt  = r_step;
        w_pos_nxt   = r_pos;
        w_dir_nxt   = r_dir;
        w_level_nxt = r_level;
        w_blink_nxt = r_blink;
        case (r_mode_q)
            MODE_COUNT: begin
                w_step_nxt = r_step + LED_ONE;
            end
            MODE_SCAN: begin
                // Bounce without repeating the end LED; a single LED stays put
                if (N_LEDS > 1) begin
                    if (r_dir == DIR_UP) begin
                        if (r_pos == POS_LAST) begin
                            w_dir_nxt = DIR_DOWN;
                            w_pos_nxt = r_pos - POS_ONE;
                        end else begin
                            w_pos_nxt = r_pos + POS_ONE;
                        end
                    end else begin
                        if (r_pos == '0) begin
                            w_dir_nxt = DIR_UP;
                            w_pos_nxt = r_pos + POS_ONE;
                        end else begin
                            w_pos_nxt = r_pos - POS_ONE;
                        end
                    end
                end
            end
            MODE_BREATHE: begin
                // Triangle ramp reversing at full scale and at zero
                if (r_dir == DIR_UP) begin
                    if (r_level == '1) begin
                        w_dir_nxt   = DIR_DOWN;
                        w_level_nxt = r_level - LVL_ONE;
                    end else begin
                        w_level_nxt = r_level + LVL_ONE;
                    end
                end else begin
                    if (r_level == '0) begin
                        w_dir_nxt   = DIR_UP;
                        w_level_nxt = r_level + LVL_ONE;
                    end else begin
                        w_level_nxt = r_level - LVL_ONE;
                    end
                end
            end
            default: begin
                w_blink_nxt = ~r_blink;
            end
        endcase
    end

    // Mode register and pattern state: a mode change restarts the pattern
    // and swallows any tick landing on the same edge
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mode_q <= MODE_COUNT;
            r_step   <= '0;
            r_pos    <= '0;
            r_dir    <= DIR_UP;
            r_level  <= '0;
            r_blink  <= 1'b0;
        end else begin
            r_mode_q <= bus.MODE;
            if (w_mode_chg) begin
                r_step  <= '0;
                r_pos   <= '0;
                r_dir   <= DIR_UP;
                r_level <= '0;
                r_blink <= 1'b0;
            end else if (w_tick_int) begin
                r_step  <= w_step_nxt;
                r_pos   <= w_pos_nxt;
                r_dir   <= w_dir_nxt;
                r_level <= w_level_nxt;
                r_blink <= w_blink_nxt;
            end
        end
    end

    // PWM phase counter free-runs, pause or not, so breathe keeps dimming
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + LVL_ONE;
        end
    end

    // Map the pattern state of the registered mode onto the LEDs
    always_comb begin
        w_led_nxt = '0;
        case (r_mode_q)
            MODE_COUNT:   w_led_nxt = r_step;
            MODE_SCAN:    w_led_nxt = LED_ONE << r_pos;
            MODE_BREATHE: w_led_nxt = {N_LEDS{(r_pwm_cnt < r_level)}};
            default:      w_led_nxt = {N_LEDS{r_blink}};
        endcase
    end

    // LED output register; frozen state keeps LEDs steady while paused
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_nxt;
        end
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern generator for the icestick-class boards; the next generation of the free-running counter blinker. A prescaler derives a step tick from CLK, and a mode-selected pattern engine drives N_LEDS outputs. Modes are binary count, bounce scan, PWM breathe and blink. Sits at the top level directly driving the board LEDs; the tick output is exported as a slow heartbeat for other blocks.

Parameters:
N_LEDS, 5, number of LED outputs (>=1)
PRESCALE_W, 20, prescaler width; one step tick every 2^PRESCALE_W CLK cycles
PWM_W, 4, breathe PWM/brightness resolution in bits (>=1)

Ports:
CLK  input  1  system clock
RST_N  input  1  reset, asynchronous, active-low
MODE  input  2  pattern select: 0 COUNT, 1 SCAN, 2 BREATHE, 3 BLINK
PAUSE  input  1  high freezes prescaler and pattern state
LED  output  N_LEDS  registered LED drive, bit 0 = first LED
TICK  output  1  registered one-cycle pulse per step tick

Behaviour:
- Reset: one clock, CLK; RST_N is asynchronous and active-low. While RST_N is low, all registers clear: LED=0, TICK=0, prescaler=0, step=0, pos=0, dir=up, level=0, blink=0, mode_q=0, pwm_cnt=0. Reset applied mid-operation clears state immediately, without waiting for a CLK edge.
- Prescaler P (PRESCALE_W bits) increments by 1 per CLK when PAUSE=0 and wraps from max to 0. When PAUSE=1, P holds.
- tick_int = (P == 2^PRESCALE_W-1) && !PAUSE. TICK is tick_int registered. On the same edge that sets TICK, the pattern state advances. The first TICK occurs 2^PRESCALE_W edges after reset release.
- LED is registered from pattern state, so the new pattern appears one edge after TICK rises.
- Mode change: mode_q registers MODE. If MODE != mode_q, the pattern state (step, pos, dir, level, blink) is cleared on that edge, and any coincident tick is ignored. P is not affected. The new pattern starts from its initial value. MODE is sampled every cycle, so a change while PAUSE=1 also clears state.
- COUNT: step (N_LEDS bits) increments per tick and wraps all-ones to 0. LED = step.
- SCAN: one-hot pos in 0..N_LEDS-1 with direction dir.
  - dir=up: pos+1. At N_LEDS-1, set dir=down and move to N_LEDS-2.
  - dir=down: pos-1. At 0, set dir=up and move to 1.
  - N_LEDS=1: pos stays at 0.
  - LED = 1<<pos. Endpoints are not repeated.
- BREATHE: level (PWM_W bits) is a triangle ramp, +1 or -1 per tick.
  - At max (2^PWM_W-1) the ramp reverses down; at 0 it reverses up. No repeated endpoint values.
  - pwm_cnt (PWM_W bits) free-runs every CLK, including while PAUSE=1.
  - LED = all bits equal to (pwm_cnt < level). Level 0 gives fully off; level max gives on for (2^PWM_W-1)/2^PWM_W of cycles.
- BLINK: blink toggles per tick. LED = all bits equal to blink.
- PAUSE asserted: TICK=0, pattern state held. LED holds, except in BREATHE, where the PWM continues at the held level. On deassert, counting resumes from the held P.
- Simultaneous PAUSE and P==max: no tick.
- Widths: all counters wrap modulo 2^width. There is no saturation except at the scan and breathe reversal points.

Test Plan:
(Bench params: N_LEDS=4, PRESCALE_W=2, PWM_W=2.)
- Reset/tick: hold RST_N=0 for 3 cycles, then release -> LED=0, TICK=0 during reset; TICK pulses for 1 cycle every 4 cycles, first on the 4th edge after release.
- COUNT: MODE=0 -> LED steps 0001, 0010, 0011 … 1111, 0000, each value updating 1 cycle after TICK.
- SCAN: MODE=1 -> LED 0001 (initial, since pos=0), 0010, 0100, 1000, 0100, 0010, 0001, 0010 on successive ticks.
- BREATHE: MODE=2 -> level 0,1,2,3,2,1,0,1; with level=2, LED=1111 for exactly 2 of each 4 cycles; with level=0, LED stays 0000.
- PAUSE: MODE=0 at LED=0101, hold PAUSE=1 for 20 cycles -> no TICK, LED stays 0101; after release, the next TICK comes after the remaining prescaler count and LED becomes 0110.
- Mode change and async reset: in SCAN at LED=1000, set MODE=3 -> state cleared, LED=0000, first blink tick gives 1111. Then pull RST_N low between CLK edges -> LED=0000 and TICK=0 immediately.
